// File: rtl/uart_frame_ctrl.sv
// Frame controller between the uart byte core and a wide processing core.
// Assembles FRAME_BYTES RX bytes into a word, hands it to the core, and serialises the result back to TX.
module uart_frame_ctrl #(
  parameter int unsigned FRAME_BYTES    = 16,
  parameter bit          MSB_FIRST      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_data_fresh_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_data_valid_o,
  input  logic                     tx_data_ack_i,
  output logic [8*FRAME_BYTES-1:0] core_din_o,
  output logic                     core_din_valid_o,
  input  logic                     core_din_ready_i,
  input  logic [8*FRAME_BYTES-1:0] core_dout_i,
  input  logic                     core_dout_valid_i,
  output logic                     core_dout_ready_o,
  output logic                     busy_o,
  output logic                     rx_overrun_o,
  output logic                     rx_timeout_o
);

  localparam int unsigned W     = 8 * FRAME_BYTES;
  localparam int unsigned CNT_W = $clog2(FRAME_BYTES + 1);
  localparam int unsigned GAP_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_DISPATCH,
    S_WAIT_RES,
    S_TX
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [W-1:0]     rx_sr_q;
  logic [W-1:0]     tx_sr_q;
  logic             din_valid_q;
  logic             dout_ready_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic             overrun_q;
  logic             timeout_q;

  // Wire byte order: the first byte on the wire lands in / leaves from the top byte when MSB_FIRST.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] sr, input logic [7:0] b);
    if (MSB_FIRST) return {sr[W-9:0], b};
    else           return {b, sr[W-1:8]};
  endfunction

  function automatic logic [W-1:0] shift_out(input logic [W-1:0] sr);
    if (MSB_FIRST) return {sr[W-9:0], 8'h00};
    else           return {8'h00, sr[W-1:8]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      din_valid_q  <= 1'b0;
      dout_ready_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      if (rx_data_fresh_i &&
          (state_q == S_DISPATCH || state_q == S_WAIT_RES || state_q == S_TX)) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (rx_data_fresh_i) begin
            rx_sr_q <= shift_in('0, rx_data_i);
            cnt_q   <= CNT_W'(1);
            gap_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RX;
          end
        end

        // A byte arriving on the expiry edge takes priority over the timeout.
        S_RX: begin
          if (rx_data_fresh_i) begin
            rx_sr_q <= shift_in(rx_sr_q, rx_data_i);
            cnt_q   <= cnt_q + CNT_W'(1);
            gap_q   <= '0;
            if (cnt_q == LAST_BYTE) begin
              din_valid_q <= 1'b1;
              state_q     <= S_DISPATCH;
            end
          end else if (TO_EN && gap_q == GAP_LAST) begin
            timeout_q <= 1'b1;
            rx_sr_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else if (TO_EN) begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        S_DISPATCH: begin
          if (core_din_ready_i) begin
            din_valid_q  <= 1'b0;
            dout_ready_q <= 1'b1;
            state_q      <= S_WAIT_RES;
          end
        end

        S_WAIT_RES: begin
          if (core_dout_valid_i) begin
            tx_sr_q      <= core_dout_i;
            cnt_q        <= '0;
            dout_ready_q <= 1'b0;
            tx_valid_q   <= 1'b1;
            state_q      <= S_TX;
          end
        end

        // Valid drops for one cycle after every ack; acks seen while valid is low are ignored.
        S_TX: begin
          if (tx_valid_q) begin
            if (tx_data_ack_i) begin
              tx_valid_q <= 1'b0;
              tx_sr_q    <= shift_out(tx_sr_q);
              cnt_q      <= cnt_q + CNT_W'(1);
              if (cnt_q == LAST_BYTE) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end else begin
            tx_valid_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data_o         = MSB_FIRST ? tx_sr_q[W-1 -: 8] : tx_sr_q[7:0];
  assign tx_data_valid_o   = tx_valid_q;
  assign core_din_o        = rx_sr_q;
  assign core_din_valid_o  = din_valid_q;
  assign core_dout_ready_o = dout_ready_q;
  assign busy_o            = busy_q;
  assign rx_overrun_o      = overrun_q;
  assign rx_timeout_o      = timeout_q;

endmodule
